// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only instruction cache (4 x 16-bit words per line) with a line-fill FSM.
// Define ICACHE_STATS_EN to add the saturating hit_cnt/miss_cnt outputs.
module icache_fetch_responder #(
  parameter int LINES   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        misalign,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 13 - IDX;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [12:0]        fill_line_q, fill_line_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic               mem_rd_q, mem_rd_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [MEM_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [MEM_LAT-1:0][1:0] pipe_k_q, pipe_k_d;

  logic [15:0]      data_q [LINES][4];
  logic [TAG_W-1:0] tag_q  [LINES];

  logic [1:0]       req_word;
  logic [IDX-1:0]   req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX-1:0]   fill_idx;
  logic             hit;
  logic             tag_we;
  logic             start_fill;
  logic             wr_en;
  logic [1:0]       wr_k;

  assign req_word = fetch_addr[2:1];
  assign req_idx  = fetch_addr[3 +: IDX];
  assign req_tag  = fetch_addr[3 + IDX +: TAG_W];
  assign fill_idx = fill_line_q[IDX-1:0];

  assign hit = (state_q == S_IDLE) && fetch_req && valid_q[req_idx] &&
               (tag_q[req_idx] == req_tag);

  // Outputs are forced quiet while reset is held, even with fetch_req high.
  assign instr_valid = rst & hit;
  assign instr       = instr_valid ? data_q[req_idx][req_word] : 16'h0000;
  assign stall       = rst & fetch_req & ~instr_valid;
  assign misalign    = fetch_req & fetch_addr[0];
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;

  // Returning read data is tagged with its word number by a MEM_LAT-deep shadow pipe.
  assign wr_en = pipe_v_q[MEM_LAT-1];
  assign wr_k  = pipe_k_q[MEM_LAT-1];

  always_comb begin
    state_d     = state_q;
    fill_line_d = fill_line_q;
    valid_d     = valid_q;
    mem_rd_d    = 1'b0;
    mem_addr_d  = 16'h0000;
    tag_we      = 1'b0;
    start_fill  = 1'b0;
    pipe_v_d[0] = mem_rd_q;
    pipe_k_d[0] = mem_addr_q[2:1];
    for (int i = 1; i < MEM_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_k_d[i] = pipe_k_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (fetch_req && !hit) begin
          start_fill  = 1'b1;
          state_d     = S_FILL;
          fill_line_d = fetch_addr[15:3];
          mem_rd_d    = 1'b1;
          mem_addr_d  = {fetch_addr[15:3], 3'b000};
        end
      end
      S_FILL: begin
        if (flush) begin
          valid_d = '0;
          state_d = S_IDLE;
        end else if (mem_addr_q[2:1] == 2'd3) begin
          state_d = S_WAIT;
        end else begin
          mem_rd_d   = 1'b1;
          mem_addr_d = {fill_line_q, mem_addr_q[2:1] + 2'd1, 1'b0};
        end
      end
      S_WAIT: begin
        if (flush) begin
          valid_d = '0;
          state_d = S_IDLE;
        end else if (wr_en && wr_k == 2'd3) begin
          valid_d[fill_idx] = 1'b1;
          tag_we            = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush drops every outstanding return, including the read issued this cycle.
    if (flush) pipe_v_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      fill_line_q <= '0;
      valid_q     <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      pipe_v_q    <= '0;
      pipe_k_q    <= '0;
    end else begin
      state_q     <= state_d;
      fill_line_q <= fill_line_d;
      valid_q     <= valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      pipe_v_q    <= pipe_v_d;
      pipe_k_q    <= pipe_k_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[fill_idx][wr_k] <= mem_rdata;
    if (tag_we) tag_q[fill_idx] <= fill_line_q[IDX +: TAG_W];
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (instr_valid && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
    if (start_fill && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= 16'h0000;
      miss_cnt_q <= 16'h0000;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Bench for icache_fetch_responder: directed scenarios then random traffic against a line-level cache model.
module tb_icache_fetch_responder;
  localparam int LINES   = 16;
  localparam int MEM_LAT = 2;
  localparam int IDX     = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        flush;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        misalign;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  icache_fetch_responder #(.LINES(LINES), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr), .flush(flush),
    .instr(instr), .instr_valid(instr_valid), .stall(stall), .misalign(misalign),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memval(input logic [15:0] a);
    logic [15:0] m;
    m = a * 16'd40503;
    return m ^ 16'h5A5A;
  endfunction

  // Backing memory: fixed latency, returns garbage whenever nothing is due.
  logic [MEM_LAT-1:0] mp_v = '0;
  logic [15:0]        mp_a [MEM_LAT];
  logic [15:0]        garbage = 16'hDEAD;
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      mp_v[i] <= mp_v[i-1];
      mp_a[i] <= mp_a[i-1];
    end
    mp_v[0] <= mem_rd;
    mp_a[0] <= mem_addr;
    garbage <= 16'($urandom);
  end
  assign mem_rdata = mp_v[MEM_LAT-1] ? memval(mp_a[MEM_LAT-1]) : garbage;

  int checks = 0;
  int failures = 0;

  // Reference: per-line valid/tag plus the age of the current fill (cycles since the miss).
  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];
  int          m_age = -1;
  logic [12:0] m_line;
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic cycle(input logic req, input logic [15:0] addr, input logic fl);
    int          idx;
    int unsigned tag;
    bit          hit;
    logic        e_iv, e_stall, e_rd;
    logic [15:0] e_instr, e_maddr;
    logic [1:0]  k;
    fetch_req  = req;
    fetch_addr = addr;
    flush      = fl;
    idx = int'(addr[3 +: IDX]);
    tag = int'(addr >> (3 + IDX));
    hit = (m_age < 0) && req && m_valid[idx] && (m_tag[idx] == tag);
    e_iv    = hit;
    e_instr = hit ? memval({addr[15:1], 1'b0}) : 16'h0000;
    e_stall = req && !hit;
    e_rd    = (m_age >= 1) && (m_age <= 4);
    k       = 2'(m_age - 1);
    e_maddr = {m_line, k, 1'b0};
    #3;
    chk("instr_valid", {15'd0, instr_valid}, {15'd0, e_iv});
    chk("instr", instr, e_instr);
    chk("stall", {15'd0, stall}, {15'd0, e_stall});
    chk("misalign", {15'd0, misalign}, {15'd0, req & addr[0]});
    chk("mem_rd", {15'd0, mem_rd}, {15'd0, e_rd});
    if (e_rd) chk("mem_addr", mem_addr, e_maddr);
`ifdef ICACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 16'(m_hits));
    chk("miss_cnt", miss_cnt, 16'(m_misses));
`endif
    @(posedge clk);
    if (hit && m_hits < 65535) m_hits++;
    if (m_age < 0) begin
      if (fl) model_clear();
      else if (req && !hit) begin
        m_age  = 1;
        m_line = addr[15:3];
        if (m_misses < 65535) m_misses++;
      end
    end else if (fl) begin
      model_clear();
      m_age = -1;
    end else if (m_age == 4 + MEM_LAT) begin
      m_valid[int'(m_line[IDX-1:0])] = 1'b1;
      m_tag[int'(m_line[IDX-1:0])]   = int'(m_line >> IDX);
      m_age = -1;
    end else begin
      m_age++;
    end
    #1;
  endtask

  task automatic run(input logic [15:0] addr, input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, addr, 1'b0);
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h0000;
    flush      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("rst_instr_valid", {15'd0, instr_valid}, 16'h0000);
      chk("rst_stall", {15'd0, stall}, 16'h0000);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_mem_rd", {15'd0, mem_rd}, 16'h0000);
      chk("rst_mem_addr", mem_addr, 16'h0000);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_cnt", hit_cnt, 16'h0000);
      chk("rst_miss_cnt", miss_cnt, 16'h0000);
`endif
      @(posedge clk);
      #1;
    end
    model_clear();
    m_age    = -1;
    m_hits   = 0;
    m_misses = 0;
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = 16'h0000;
    flush      = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);

    // Cold miss on 0x0000, then hits on the rest of the line.
    run(16'h0000, 6 + MEM_LAT);
    run(16'h0002, 1);
    run(16'h0004, 1);
    run(16'h0006, 1);

    // Same index, different tag: conflict refills.
    run(16'h0080, 6 + MEM_LAT);
    run(16'h0000, 6 + MEM_LAT);

    // Flush on the second fill cycle aborts, then a full refill.
    cycle(1'b1, 16'h0010, 1'b0);
    cycle(1'b1, 16'h0010, 1'b0);
    cycle(1'b1, 16'h0010, 1'b1);
    cycle(1'b0, 16'h0010, 1'b0);
    run(16'h0010, 6 + MEM_LAT);

    // Flush in IDLE with a hit and a same-cycle miss.
    cycle(1'b1, 16'h0012, 1'b1);
    cycle(1'b1, 16'h0030, 1'b1);
    run(16'h0012, 6 + MEM_LAT);

    // Reset during WAIT; previously cached line must miss afterwards.
    run(16'h0020, 6);
    do_reset();
    cycle(1'b0, 16'h0000, 1'b0);
    run(16'h0012, 6 + MEM_LAT);
    run(16'h0020, 6 + MEM_LAT);

    // Misaligned fetch returns the aligned word.
    run(16'h0003, 6 + MEM_LAT);
    run(16'h0005, 1);

    // Random traffic over two tags and four indexes.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      logic [8:0]  t;
      t = ($urandom_range(0, 1) == 1) ? 9'h1A5 : 9'h000;
      a = {t, 2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0)};
      cycle($urandom_range(0, 9) != 0, a, $urandom_range(0, 24) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
